// File: rtl/hub75_panel_receiver_if.sv
// HUB75 panel bus: the signals a transmitter drives towards an LED panel.
// The master modport is the transmitter side; the slave modport is the receiver.
interface hub75_panel_receiver_if;
  logic       led_clk_in;
  logic       latch_enable;
  logic       plane_oe;
  logic [4:0] ABCDE;
  logic       r0, g0, b0;
  logic       r1, g1, b1;

  modport master (
    output led_clk_in, latch_enable, plane_oe, ABCDE,
    output r0, g0, b0, r1, g1, b1
  );

  modport slave (
    input led_clk_in, latch_enable, plane_oe, ABCDE,
    input r0, g0, b0, r1, g1, b1
  );
endinterface

// File: rtl/hub75_panel_receiver.sv
// Panel-side HUB75 receiver: oversamples the bus, rebuilds the pixel stream and
// per-latch line records, measures OE on-time and checks the row sequence.
module hub75_panel_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int ON_W        = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [9:0]           pixels_per_row,
  hub75_panel_receiver_if.slave hub,
  output logic                 pix_valid,
  output logic [9:0]           pix_index,
  output logic [5:0]           pix_data,
  output logic                 line_valid,
  output logic [4:0]           line_row,
  output logic [9:0]           line_pixels,
  output logic                 line_err,
  output logic [ON_W-1:0]      on_time,
  output logic                 frame_start,
  output logic                 row_seq_err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  // Packed bus: [13] led_clk, [12] latch, [11] oe_n, [10:6] row, [5:0] colour.
  localparam int IN_W = 14;
  // OE resets to its inactive (high) level so no on-time is counted out of reset.
  localparam logic [IN_W-1:0] SYNC_RST = 14'h0800;

  logic [IN_W-1:0] raw_in;
  logic [IN_W-1:0] sync_d [SYNC_STAGES];
  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic [IN_W-1:0] s;
  logic [1:0]      edge_d, edge_q;

  assign raw_in = {hub.led_clk_in, hub.latch_enable, hub.plane_oe, hub.ABCDE,
                   hub.r1, hub.g1, hub.b1, hub.r0, hub.g0, hub.b0};

  always_comb begin
    sync_d[0] = raw_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign edge_d = s[13:12];

  logic led_rise, latch_rise, latch_fall, oe_lit;
  assign led_rise   =  s[13] & ~edge_q[1];
  assign latch_rise =  s[12] & ~edge_q[0];
  assign latch_fall = ~s[12] &  edge_q[0];
  assign oe_lit     = ~s[11];

  state_t          state_d, state_q;
  logic [9:0]      cnt_d, cnt_q;
  logic            ovf_d, ovf_q;
  logic [ON_W-1:0] on_cnt_d, on_cnt_q;
  logic [4:0]      prev_row_d, prev_row_q;
  logic            first_d, first_q;
  logic            pix_valid_d, pix_valid_q;
  logic [9:0]      pix_index_d, pix_index_q;
  logic [5:0]      pix_data_d, pix_data_q;
  logic            line_valid_d, line_valid_q;
  logic [4:0]      line_row_d, line_row_q;
  logic [9:0]      line_pixels_d, line_pixels_q;
  logic            line_err_d, line_err_q;
  logic [ON_W-1:0] on_time_d, on_time_q;
  logic            frame_start_d, frame_start_q;
  logic            row_seq_err_d, row_seq_err_q;

  logic [9:0]      cnt_inc;
  logic            ovf_inc;
  logic [ON_W-1:0] on_inc;
  logic [4:0]      row, next_row;
  logic            row_step_ok;

  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    if (led_rise) begin
      if (cnt_q == 10'h3FF) ovf_inc = 1'b1;
      else                  cnt_inc = cnt_q + 10'd1;
    end
    on_inc      = (oe_lit && on_cnt_q != '1) ? on_cnt_q + ON_W'(1) : on_cnt_q;
    row         = s[10:6];
    next_row    = prev_row_q + 5'd1;
    // Repeats are legal: BCM latches the same row once per plane.
    row_step_ok = (row == prev_row_q) || (row == next_row) || (row == 5'd0);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    on_cnt_d      = on_cnt_q;
    prev_row_d    = prev_row_q;
    first_d       = first_q;
    pix_valid_d   = 1'b0;
    pix_index_d   = pix_index_q;
    pix_data_d    = pix_data_q;
    line_valid_d  = 1'b0;
    line_row_d    = line_row_q;
    line_pixels_d = line_pixels_q;
    line_err_d    = line_err_q;
    on_time_d     = on_time_q;
    frame_start_d = 1'b0;
    row_seq_err_d = row_seq_err_q;

    if (!enable) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      ovf_d         = 1'b0;
      on_cnt_d      = '0;
      prev_row_d    = '0;
      first_d       = 1'b1;
      pix_index_d   = '0;
      pix_data_d    = '0;
      line_row_d    = '0;
      line_pixels_d = '0;
      line_err_d    = 1'b0;
      on_time_d     = '0;
      row_seq_err_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      state_d = S_SHIFT;
    end else begin
      cnt_d    = cnt_inc;
      ovf_d    = ovf_inc;
      on_cnt_d = on_inc;
      if (led_rise) begin
        pix_valid_d = 1'b1;
        pix_index_d = cnt_q;
        pix_data_d  = s[5:0];
      end
      // A pixel landing with the latch edge belongs to the line being closed.
      if (state_q == S_SHIFT && latch_rise) begin
        line_valid_d  = 1'b1;
        line_row_d    = row;
        line_pixels_d = cnt_inc;
        line_err_d    = (cnt_inc != pixels_per_row) || ovf_inc;
        on_time_d     = on_inc;
        frame_start_d = !first_q && (row == 5'd0) && (prev_row_q != 5'd0);
        if (!first_q && !row_step_ok) row_seq_err_d = 1'b1;
        prev_row_d    = row;
        first_d       = 1'b0;
        cnt_d         = '0;
        ovf_d         = 1'b0;
        on_cnt_d      = '0;
        state_d       = S_LATCH;
      end else if (state_q == S_LATCH && latch_fall) begin
        state_d = S_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      edge_q        <= '0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      on_cnt_q      <= '0;
      prev_row_q    <= '0;
      first_q       <= 1'b1;
      pix_valid_q   <= 1'b0;
      pix_index_q   <= '0;
      pix_data_q    <= '0;
      line_valid_q  <= 1'b0;
      line_row_q    <= '0;
      line_pixels_q <= '0;
      line_err_q    <= 1'b0;
      on_time_q     <= '0;
      frame_start_q <= 1'b0;
      row_seq_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      edge_q        <= edge_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      on_cnt_q      <= on_cnt_d;
      prev_row_q    <= prev_row_d;
      first_q       <= first_d;
      pix_valid_q   <= pix_valid_d;
      pix_index_q   <= pix_index_d;
      pix_data_q    <= pix_data_d;
      line_valid_q  <= line_valid_d;
      line_row_q    <= line_row_d;
      line_pixels_q <= line_pixels_d;
      line_err_q    <= line_err_d;
      on_time_q     <= on_time_d;
      frame_start_q <= frame_start_d;
      row_seq_err_q <= row_seq_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_index   = pix_index_q;
  assign pix_data    = pix_data_q;
  assign line_valid  = line_valid_q;
  assign line_row    = line_row_q;
  assign line_pixels = line_pixels_q;
  assign line_err    = line_err_q;
  assign on_time     = on_time_q;
  assign frame_start = frame_start_q;
  assign row_seq_err = row_seq_err_q;

endmodule

// File: tb/tb_hub75_panel_receiver.sv
// Bench for hub75_panel_receiver: table-driven line vectors, hand-written corner
// sequences and randomized lines checked against a line-level reference model.
module tb_hub75_panel_receiver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, enable;
  logic [9:0]  ppr;
  logic        pix_valid, line_valid, line_err, frame_start, row_seq_err;
  logic [9:0]  pix_index, line_pixels;
  logic [5:0]  pix_data;
  logic [4:0]  line_row;
  logic [15:0] on_time;

  hub75_panel_receiver_if hub();

  hub75_panel_receiver #(.SYNC_STAGES(2), .ON_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .enable(enable), .pixels_per_row(ppr), .hub(hub),
    .pix_valid(pix_valid), .pix_index(pix_index), .pix_data(pix_data),
    .line_valid(line_valid), .line_row(line_row), .line_pixels(line_pixels),
    .line_err(line_err), .on_time(on_time), .frame_start(frame_start),
    .row_seq_err(row_seq_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [9:0] idx; logic [5:0] d; } pix_t;
  typedef struct {
    logic [4:0] row; logic [9:0] pixels; logic err;
    logic [15:0] on; logic fs; logic seq;
  } line_t;
  typedef struct {
    bit pre_disable; int npix; logic [4:0] row; logic [9:0] ppr;
    int exp_pix; bit exp_err; bit exp_fs; bit exp_seq;
  } vec_t;

  pix_t  pix_q[$];
  line_t line_q[$];

  always @(negedge clk) begin
    if (pix_valid)  pix_q.push_back('{pix_index, pix_data});
    if (line_valid) line_q.push_back('{line_row, line_pixels, line_err, on_time,
                                       frame_start, row_seq_err});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_pixel(logic [5:0] d);
    {hub.r1, hub.g1, hub.b1, hub.r0, hub.g0, hub.b0} = d;
    hub.led_clk_in = 1'b0;
    tick(3);
    hub.led_clk_in = 1'b1;
    tick(3);
  endtask

  task automatic latch_line(logic [4:0] row);
    hub.ABCDE = row;
    tick(3);
    hub.latch_enable = 1'b1;
    tick(4);
    hub.latch_enable = 1'b0;
    tick(5);
  endtask

  task automatic check_stream(string name, logic [5:0] sent[$]);
    int nbad = 0;
    int n;
    check({name, "/pix_cnt"}, 32'(pix_q.size()), 32'(sent.size()));
    n = (pix_q.size() < sent.size()) ? pix_q.size() : sent.size();
    for (int i = 0; i < n; i++) begin
      if (pix_q[i].idx !== 10'((i > 1023) ? 1023 : i) || pix_q[i].d !== sent[i]) nbad++;
    end
    check({name, "/pix_stream_bad"}, 32'(nbad), 32'd0);
  endtask

  task automatic do_line(string name, int npix, logic [4:0] row, logic [9:0] ppr_v,
                         int oe_cyc, bit rnd, int exp_pix, bit exp_err, int exp_on,
                         bit exp_fs, bit exp_seq);
    logic [5:0] sent[$];
    logic [5:0] d;
    line_t l;
    pix_q.delete();
    line_q.delete();
    ppr = ppr_v;
    if (oe_cyc > 0) begin
      hub.plane_oe = 1'b0;
      tick(oe_cyc);
      hub.plane_oe = 1'b1;
    end
    for (int i = 0; i < npix; i++) begin
      d = rnd ? 6'($urandom) : ((i % 2 == 0) ? 6'h2A : 6'h15);
      sent.push_back(d);
      shift_pixel(d);
    end
    latch_line(row);
    check_stream(name, sent);
    check({name, "/line_cnt"}, 32'(line_q.size()), 32'd1);
    if (line_q.size() > 0) begin
      l = line_q[0];
      check({name, "/row"},    32'(l.row),    32'(row));
      check({name, "/pixels"}, 32'(l.pixels), 32'(exp_pix));
      check({name, "/err"},    32'(l.err),    32'(exp_err));
      check({name, "/on"},     32'(l.on),     32'(exp_on));
      check({name, "/fs"},     32'(l.fs),     32'(exp_fs));
      check({name, "/seq"},    32'(l.seq),    32'(exp_seq));
    end
    $display("line %s: npix=%0d row=%0d lines=%0d", name, npix, row, line_q.size());
  endtask

  task automatic disable_midline(string name);
    pix_q.delete();
    line_q.delete();
    for (int i = 0; i < 20; i++) shift_pixel((i % 2 == 0) ? 6'h2A : 6'h15);
    enable = 1'b0;
    tick(1);
    check({name, "/pix_index"},   32'(pix_index),   32'd0);
    check({name, "/pix_data"},    32'(pix_data),    32'd0);
    check({name, "/line_pixels"}, 32'(line_pixels), 32'd0);
    check({name, "/row_seq_err"}, 32'(row_seq_err), 32'd0);
    tick(3);
    check({name, "/no_line"},     32'(line_q.size()), 32'd0);
    enable = 1'b1;
    tick(3);
  endtask

  vec_t tbl[11];

  task automatic apply_vec(int k);
    if (tbl[k].pre_disable) disable_midline($sformatf("vec%0d_dis", k));
    do_line($sformatf("vec%0d", k), tbl[k].npix, tbl[k].row, tbl[k].ppr, 0, 1'b0,
            tbl[k].exp_pix, tbl[k].exp_err, 0, tbl[k].exp_fs, tbl[k].exp_seq);
  endtask

  int  m_prev, npix, oe_cyc, exp_pix, r, pv;
  bit  m_first, m_seq, exp_err, exp_fs;

  initial begin
    tbl[0]  = '{0, 64,  3, 64, 64, 0, 0, 0};
    tbl[1]  = '{0,  8,  3,  8,  8, 0, 0, 0};
    tbl[2]  = '{0,  7,  4,  9,  7, 1, 0, 0};
    tbl[3]  = '{0,  0,  5,  0,  0, 0, 0, 0};
    tbl[4]  = '{1,  3, 30,  3,  3, 0, 0, 0};
    tbl[5]  = '{0,  4, 31,  4,  4, 0, 0, 0};
    tbl[6]  = '{0,  2,  0,  2,  2, 0, 1, 0};
    tbl[7]  = '{0,  5,  1,  5,  5, 0, 0, 0};
    tbl[8]  = '{0,  3,  5,  3,  3, 0, 0, 1};
    tbl[9]  = '{0,  3,  6,  2,  3, 1, 0, 1};
    tbl[10] = '{1,  4,  2,  4,  4, 0, 0, 0};

    resetn = 1'b0; enable = 1'b0; ppr = '0;
    hub.led_clk_in = 1'b0; hub.latch_enable = 1'b0; hub.plane_oe = 1'b1;
    hub.ABCDE = '0;
    {hub.r1, hub.g1, hub.b1, hub.r0, hub.g0, hub.b0} = '0;
    tick(3);
    check("rst/pix_valid",   32'(pix_valid),   32'd0);
    check("rst/line_valid",  32'(line_valid),  32'd0);
    check("rst/on_time",     32'(on_time),     32'd0);
    check("rst/row_seq_err", 32'(row_seq_err), 32'd0);
    resetn = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(3);

    for (int k = 0; k < 4; k++) apply_vec(k);

    do_line("on500",  2, 5, 2, 500,   1'b0, 2, 0, 500,   0, 0);
    do_line("on_sat", 0, 5, 0, 70000, 1'b0, 0, 0, 65535, 0, 0);

    // Pixel edge and latch edge in the same raw cycle after 9 pixels.
    pix_q.delete();
    line_q.delete();
    ppr = 10'd10;
    hub.ABCDE = 5'd6;
    for (int i = 0; i < 9; i++) shift_pixel((i % 2 == 0) ? 6'h2A : 6'h15);
    {hub.r1, hub.g1, hub.b1, hub.r0, hub.g0, hub.b0} = 6'h3C;
    hub.led_clk_in = 1'b0;
    tick(3);
    hub.led_clk_in = 1'b1;
    hub.latch_enable = 1'b1;
    tick(4);
    hub.latch_enable = 1'b0;
    tick(5);
    check("simul/pix_cnt", 32'(pix_q.size()), 32'd10);
    if (pix_q.size() >= 10) begin
      check("simul/last_index", 32'(pix_q[9].idx), 32'd9);
      check("simul/last_data",  32'(pix_q[9].d),   32'h3C);
    end
    check("simul/line_cnt", 32'(line_q.size()), 32'd1);
    if (line_q.size() > 0) begin
      check("simul/pixels", 32'(line_q[0].pixels), 32'd10);
      check("simul/err",    32'(line_q[0].err),    32'd0);
      check("simul/row",    32'(line_q[0].row),    32'd6);
    end
    $display("line simul: npix=10 row=6 lines=%0d", line_q.size());
    do_line("after_simul", 4, 7, 4, 0, 1'b0, 4, 0, 0, 0, 0);

    do_line("ovf", 1030, 8, 1023, 0, 1'b0, 1023, 1, 0, 0, 0);

    for (int k = 4; k < 11; k++) apply_vec(k);

    // Asynchronous reset mid-line.
    pix_q.delete();
    line_q.delete();
    for (int i = 0; i < 20; i++) shift_pixel((i % 2 == 0) ? 6'h2A : 6'h15);
    resetn = 1'b0;
    #1;
    check("arst/pix_index",   32'(pix_index),   32'd0);
    check("arst/pix_data",    32'(pix_data),    32'd0);
    check("arst/line_row",    32'(line_row),    32'd0);
    check("arst/line_pixels", 32'(line_pixels), 32'd0);
    hub.led_clk_in = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(4);
    check("arst/no_line", 32'(line_q.size()), 32'd0);
    do_line("after_rst", 5, 0, 5, 0, 1'b0, 5, 0, 0, 0, 0);

    // Randomized lines against the line-level model.
    m_prev = 0; m_first = 1'b0; m_seq = 1'b0;
    for (int n = 0; n < 20; n++) begin
      npix   = $urandom_range(0, 24);
      case ($urandom_range(0, 3))
        0:       r = m_prev;
        1:       r = (m_prev + 1) % 32;
        2:       r = 0;
        default: r = $urandom_range(0, 31);
      endcase
      pv      = ($urandom_range(0, 1) == 1) ? npix : $urandom_range(0, 30);
      oe_cyc  = $urandom_range(0, 150);
      exp_pix = (npix > 1023) ? 1023 : npix;
      exp_err = (npix > 1023) || (exp_pix != pv);
      exp_fs  = !m_first && r == 0 && m_prev != 0;
      if (!m_first && r != m_prev && r != (m_prev + 1) % 32 && r != 0) m_seq = 1'b1;
      m_prev  = r;
      m_first = 1'b0;
      do_line($sformatf("rnd%0d", n), npix, 5'(r), 10'(pv), oe_cyc, 1'b1, exp_pix,
              exp_err, (oe_cyc > 65535) ? 65535 : oe_cyc, exp_fs, m_seq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
